// File: rtl/servo_pwm_driver_pkg.sv
// -----------------------------------------------------------------------------
// servo_pwm_driver_pkg
// Shared definitions for the servo PWM driver and its clients: the frame-timer
// state type, default timing constants for a 50 MHz clock, and the pulse-width
// function.
// The sweep controller uses the same function to compute dwell times.
// -----------------------------------------------------------------------------
package servo_pwm_driver_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pwm_state_e;

   localparam int unsigned DEF_FRAME_CYCLES = 1_000_000;  // 20 ms at 50 MHz
   localparam int unsigned DEF_MIN_PULSE    = 50_000;     // 1 ms
   localparam int unsigned DEF_STEP_CYCLES  = 196;

   // High-time in clock cycles for a given angle
   function automatic logic [31:0] pulse_cycles(
      input logic [7:0]  angle,
      input int unsigned min_pulse   = DEF_MIN_PULSE,
      input int unsigned step_cycles = DEF_STEP_CYCLES
   );
      return min_pulse + 32'(angle) * step_cycles;
   endfunction

   // Counter/width register size: wide enough for a full frame, never under 20 bits
   function automatic int unsigned width_bits(input int unsigned frame_cycles);
      return ($clog2(frame_cycles) > 20) ? $clog2(frame_cycles) : 20;
   endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// -----------------------------------------------------------------------------
// pwm_frame_timer
// Frame counter and IDLE/HIGH/LOW sequencer for one PWM channel.
// Ports:
//   clock, resetn  : system clock, asynchronous active-low reset
//   enable         : run request, honoured only at frame boundaries
//   width          : high-time for the next frame, captured at the boundary
//   boundary       : combinational, high on the cycle a new frame is launched
//   frame_start    : registered one-cycle strobe on the first cycle of a frame
//   frame_end      : combinational, high on the last cycle of a running frame
//   pwm_out        : registered PWM output
//   busy           : high while a frame is in progress
// -----------------------------------------------------------------------------
module pwm_frame_timer
   import servo_pwm_driver_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
   parameter int unsigned CW           = width_bits(FRAME_CYCLES)
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          enable,
   input  logic [CW-1:0] width,
   output logic          boundary,
   output logic          frame_start,
   output logic          frame_end,
   output logic          pwm_out,
   output logic          busy
);

   localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

   pwm_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] width_q, width_d;
   logic          pwm_q, pwm_d;
   logic          fs_q, fs_d;
   logic          last;

   assign last      = (cnt_q == LAST);
   // A new frame launches from IDLE or from the final LOW cycle, only if enabled
   assign boundary  = enable && ((state_q == IDLE) || ((state_q == LOW) && last));
   assign frame_end = (state_q == LOW) && last;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      width_d = width_q;
      pwm_d   = pwm_q;
      fs_d    = 1'b0;
      if (boundary) begin
         state_d = HIGH;
         cnt_d   = '0;
         width_d = width;
         pwm_d   = 1'b1;
         fs_d    = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               pwm_d = 1'b0;
            end
            HIGH: begin
               if (cnt_q == width_q - CW'(1)) begin
                  state_d = LOW;
                  pwm_d   = 1'b0;
               end
            end
            LOW: begin
               if (last) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  pwm_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               pwm_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         width_q <= '0;
         pwm_q   <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         width_q <= width_d;
         pwm_q   <= pwm_d;
         fs_q    <= fs_d;
      end
   end

   assign pwm_out     = pwm_q;
   assign frame_start = fs_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: rtl/servo_pwm_driver.sv
// -----------------------------------------------------------------------------
// servo_pwm_driver
// 50 Hz hobby-servo PWM generator fed by a valid/ready angle stream. New angles
// are buffered in a one-deep pending register and applied only at frame
// boundaries. Reports when the angle has been stable long enough to settle.
// Ports:
//   clock, resetn             : system clock, asynchronous active-low reset
//   enable                    : run request, sampled at frame boundaries
//   angle/angle_valid/ready   : angle handshake (accept on valid && ready)
//   pwm_out                   : registered servo control output
//   frame_start               : one-cycle strobe on the first cycle of a frame
//   active_angle              : angle driving the current frame
//   settled                   : angle unchanged for SETTLE_FRAMES frames
//   busy                      : frame in progress
// -----------------------------------------------------------------------------
module servo_pwm_driver
   import servo_pwm_driver_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES  = DEF_FRAME_CYCLES,
   parameter int unsigned MIN_PULSE     = DEF_MIN_PULSE,
   parameter int unsigned STEP_CYCLES   = DEF_STEP_CYCLES,
   parameter int unsigned SETTLE_FRAMES = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   input  logic [7:0] angle,
   input  logic       angle_valid,
   output logic       angle_ready,
   output logic       pwm_out,
   output logic       frame_start,
   output logic [7:0] active_angle,
   output logic       settled,
   output logic       busy
);

   localparam int unsigned CW = width_bits(FRAME_CYCLES);
   localparam int unsigned SW = (SETTLE_FRAMES < 1) ? 1 : $clog2(SETTLE_FRAMES + 1);

   // The widest pulse must leave a non-empty LOW phase
   if (MIN_PULSE + 255 * STEP_CYCLES >= FRAME_CYCLES) begin : g_bad_timing
      $error("servo_pwm_driver: MIN_PULSE + 255*STEP_CYCLES must be below FRAME_CYCLES");
   end

   logic [7:0]    pending_q, pending_d;
   logic          pending_full_q, pending_full_d;
   logic [7:0]    active_q, active_d;
   logic [SW-1:0] settle_q, settle_d;

   logic          boundary;
   logic          frame_end;
   logic          accept;
   logic          load;
   logic [CW-1:0] width_next;

   assign angle_ready = !pending_full_q || boundary;
   assign accept      = angle_valid && angle_ready;
   assign load        = boundary && pending_full_q;

   always_comb begin
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      active_d       = active_q;
      settle_d       = settle_q;

      // Load before accept so a same-cycle offer refills the freed slot
      if (load) begin
         active_d       = pending_q;
         pending_full_d = 1'b0;
      end
      if (accept) begin
         pending_d      = angle;
         pending_full_d = 1'b1;
      end

      if (frame_end && !enable) begin
         settle_d = '0;
      end else if (load && (pending_q != active_q)) begin
         settle_d = '0;
      end else if (frame_end && (settle_q != SW'(SETTLE_FRAMES))) begin
         settle_d = settle_q + SW'(1);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         active_q       <= '0;
         settle_q       <= '0;
      end else begin
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         active_q       <= active_d;
         settle_q       <= settle_d;
      end
   end

   // Width follows the angle that will be active in the frame being launched
   assign width_next = CW'(pulse_cycles(active_d, MIN_PULSE, STEP_CYCLES));

   pwm_frame_timer #(
      .FRAME_CYCLES (FRAME_CYCLES),
      .CW           (CW)
   ) u_timer (
      .clock       (clock),
      .resetn      (resetn),
      .enable      (enable),
      .width       (width_next),
      .boundary    (boundary),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .pwm_out     (pwm_out),
      .busy        (busy)
   );

   assign active_angle = active_q;
   assign settled      = (settle_q == SW'(SETTLE_FRAMES));

endmodule

// File: tb/tb_servo_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_driver
// Directed and randomized checks of servo_pwm_driver against a frame-position
// reference model, with short frame timing.
// -----------------------------------------------------------------------------
module tb_servo_pwm_driver;

   localparam int FRAME  = 1000;
   localparam int MINP   = 50;
   localparam int STEP   = 3;
   localparam int SETTLE = 4;

   logic       clock  = 1'b0;
   logic       resetn = 1'b0;
   logic       en     = 1'b0;
   logic       valid  = 1'b0;
   logic [7:0] ang    = 8'd0;

   logic       angle_ready;
   logic       pwm_out;
   logic       frame_start;
   logic [7:0] active_angle;
   logic       settled;
   logic       busy;

   always #5 clock = ~clock;

   servo_pwm_driver #(
      .FRAME_CYCLES  (FRAME),
      .MIN_PULSE     (MINP),
      .STEP_CYCLES   (STEP),
      .SETTLE_FRAMES (SETTLE)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .enable       (en),
      .angle        (ang),
      .angle_valid  (valid),
      .angle_ready  (angle_ready),
      .pwm_out      (pwm_out),
      .frame_start  (frame_start),
      .active_angle (active_angle),
      .settled      (settled),
      .busy         (busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: a running flag plus position within the frame
   bit       m_run;
   int       m_pos;
   int       m_w;
   int       m_settle;
   bit [7:0] m_active;
   bit [7:0] m_pend;
   bit       m_full;
   bit       m_acc;

   // Observation history
   int hi_cnt;
   bit hi_valid;
   int busy_cnt;
   int hi_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit m_boundary();
      return en && (!m_run || (m_pos == FRAME - 1));
   endfunction

   task automatic model_reset();
      m_run = 0; m_pos = 0; m_w = 0; m_settle = 0;
      m_active = 0; m_pend = 0; m_full = 0; m_acc = 0;
   endtask

   task automatic model_step();
      bit bnd;
      bit done;
      bnd   = m_boundary();
      done  = m_run && (m_pos == FRAME - 1);
      m_acc = valid && (!m_full || bnd);
      if (done && !en) m_settle = 0;
      else if (bnd && m_full && (m_pend != m_active)) m_settle = 0;
      else if (done && (m_settle < SETTLE)) m_settle++;
      if (bnd && m_full) begin
         m_active = m_pend;
         m_full   = 0;
      end
      if (m_acc) begin
         m_pend = ang;
         m_full = 1;
      end
      if (bnd) begin
         m_run = 1;
         m_pos = 0;
         m_w   = MINP + int'(m_active) * STEP;
      end else if (done) begin
         m_run = 0;
         m_pos = 0;
      end else if (m_run) begin
         m_pos++;
      end
   endtask

   task automatic check_outputs();
      chk("pwm_out", pwm_out, m_run && (m_pos < m_w));
      chk("frame_start", frame_start, m_run && (m_pos == 0));
      chk("busy", busy, m_run);
      chk("active_angle", active_angle, m_active);
      chk("settled", settled, m_settle == SETTLE);
   endtask

   // One clock: check ready against current inputs, clock, then check outputs
   task automatic tick();
      #1;
      chk("angle_ready", angle_ready, !m_full || m_boundary());
      @(posedge clock);
      if (!resetn) model_reset();
      else model_step();
      #1;
      check_outputs();
      if (frame_start) begin
         if (hi_valid) hi_q.push_back(hi_cnt);
         hi_cnt   = 0;
         hi_valid = 1;
      end
      if (pwm_out) hi_cnt++;
      if (busy) busy_cnt++;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic run_until_pushes(input int k);
      int budget;
      budget = (k + 1) * FRAME;
      while ((hi_q.size() < k) && (budget > 0)) begin
         tick();
         budget--;
      end
      chk("frames_seen", hi_q.size(), k);
   endtask

   task automatic offer(input bit [7:0] a);
      ang   = a;
      valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   initial begin
      int budget;
      model_reset();
      hi_cnt = 0; hi_valid = 0; busy_cnt = 0;

      // Reset state
      run(3);
      chk("rst_ready", angle_ready, 1'b1);
      resetn = 1'b1;

      // Angle 0 accepted while idle, then run
      hi_q.delete();
      offer(8'd0);
      en = 1'b1;
      run_until_pushes(2);
      chk("w_angle0_a", hi_q[0], 50);
      chk("w_angle0_b", hi_q[1], 50);

      // Mid-frame update to 100 takes effect next frame
      run(200);
      offer(8'd100);
      hi_q.delete();
      run_until_pushes(2);
      chk("w_before_100", hi_q[0], 50);
      chk("w_angle100", hi_q[1], 350);
      chk("active_100", active_angle, 8'd100);

      // Back-to-back offers: 10 held, 20 stalled to the boundary
      run(400);
      hi_q.delete();
      ang = 8'd10; valid = 1'b1;
      tick();
      ang = 8'd20;
      chk("stall_ready", angle_ready, 1'b0);
      budget = FRAME + 5;
      do begin
         tick();
         budget--;
      end while (!m_acc && (budget > 0));
      chk("accept20_in_time", m_acc, 1'b1);
      valid = 1'b0;
      run_until_pushes(3);
      chk("w_cur_frame", hi_q[0], 350);
      chk("w_angle10", hi_q[1], 80);
      chk("w_angle20", hi_q[2], 110);

      // Settle behaviour
      offer(8'd200);
      hi_q.delete();
      run_until_pushes(1);
      chk("active_200", active_angle, 8'd200);
      hi_q.delete();
      run_until_pushes(3);
      chk("settled_after3", settled, 1'b0);
      hi_q.delete();
      run_until_pushes(1);
      chk("settled_after4", settled, 1'b1);
      offer(8'd200);
      hi_q.delete();
      run_until_pushes(1);
      chk("settled_reload_same", settled, 1'b1);
      offer(8'd201);
      hi_q.delete();
      run_until_pushes(1);
      chk("settled_new_angle", settled, 1'b0);
      chk("active_201", active_angle, 8'd201);

      // Randomized traffic with occasional enable toggles
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 1499) == 0) en = ~en;
         valid = ($urandom_range(0, 63) == 0);
         ang   = 8'($urandom);
         tick();
      end
      valid = 1'b0;
      en    = 1'b1;

      // Drop enable mid-HIGH: frame completes, then idle
      hi_q.delete();
      run_until_pushes(1);
      run(10);
      en = 1'b0;
      busy_cnt = 0;
      run(1500);
      chk("busy_tail", busy_cnt, FRAME - 11);
      chk("idle_frame_high", hi_cnt, MINP + int'(active_angle) * STEP);
      chk("idle_pwm", pwm_out, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_settled", settled, 1'b0);

      // Asynchronous reset mid-pulse
      en = 1'b1;
      offer(8'd255);
      hi_q.delete();
      run_until_pushes(1);
      run(20);
      chk("pre_reset_pwm", pwm_out, 1'b1);
      resetn = 1'b0;
      #1;
      chk("async_rst_pwm", pwm_out, 1'b0);
      model_reset();
      check_outputs();
      chk("async_rst_ready", angle_ready, 1'b1);
      run(3);
      resetn = 1'b1;
      en     = 1'b0;
      run(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
